hr_cnt: RTL

//  BCD hours counter for the alarm clock timekeeping chain. Sits directly downstream of
//  the minutes-tens divide-by-6 stage: its en input is that stage's inc_nxt, so it advances

---
 rtl/hr_cnt.sv | 121 ++++++++++++
 1 files changed

// File: rtl/hr_cnt.sv
// BCD hours counter with time-set step and day-rollover output.
// Define HR12_MODE_EN for the 12-hour build with an AM/PM flag; the default is 24-hour.
module hr_cnt #(
  parameter int RST_HOUR = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       set_inc,
  output logic [3:0] hr_ones,
  output logic [3:0] hr_tens,
  output logic       pm,
  output logic       inc_nxt
);

  generate
    if (RST_HOUR < 0 || RST_HOUR > 23) begin : gBadRstHour
      $error("hr_cnt: RST_HOUR %0d outside 0..23", RST_HOUR);
    end
  endgenerate

`ifdef HR12_MODE_EN
  localparam int   RST_DISP = ((RST_HOUR % 12) == 0) ? 12 : (RST_HOUR % 12);
  localparam logic RST_PM   = (RST_HOUR >= 12);
`else
  localparam int   RST_DISP = RST_HOUR;
`endif
  localparam logic [3:0] RST_TENS = 4'(RST_DISP / 10);
  localparam logic [3:0] RST_ONES = 4'(RST_DISP % 10);

  logic [3:0] ones_q, ones_d;
  logic [3:0] tens_q, tens_d;
  logic       step;
  logic       illegal;

  assign step    = en | set_inc;
  assign hr_ones = ones_q;
  assign hr_tens = tens_q;

`ifdef HR12_MODE_EN
  logic pm_q, pm_d;
  logic at11, at12;

  // Display runs 12, 01..11; illegal states (00 or above 12) recover to 12 with pm kept.
  always_comb begin
    ones_d  = ones_q;
    tens_d  = tens_q;
    pm_d    = pm_q;
    illegal = (ones_q > 4'd9) || (tens_q > 4'd1) ||
              ((tens_q == 4'd0) && (ones_q == 4'd0)) ||
              ((tens_q == 4'd1) && (ones_q > 4'd2));
    at11    = (tens_q == 4'd1) && (ones_q == 4'd1);
    at12    = (tens_q == 4'd1) && (ones_q == 4'd2);
    inc_nxt = en & at11 & pm_q;
    if (step) begin
      if (illegal) begin
        tens_d = 4'd1;
        ones_d = 4'd2;
      end else if (at12) begin
        tens_d = 4'd0;
        ones_d = 4'd1;
      end else if (at11) begin
        tens_d = 4'd1;
        ones_d = 4'd2;
        pm_d   = ~pm_q;
      end else if (ones_q == 4'd9) begin
        tens_d = 4'd1;
        ones_d = 4'd0;
      end else begin
        ones_d = ones_q + 4'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pm_q <= RST_PM;
    end else begin
      pm_q <= pm_d;
    end
  end

  assign pm = pm_q;
`else
  logic at23;

  // Illegal states share the 23->00 path so any fault clears on the next step.
  always_comb begin
    ones_d  = ones_q;
    tens_d  = tens_q;
    illegal = (ones_q > 4'd9) || (tens_q > 4'd2) ||
              ((tens_q == 4'd2) && (ones_q > 4'd3));
    at23    = (tens_q == 4'd2) && (ones_q == 4'd3);
    inc_nxt = en & at23;
    if (step) begin
      if (illegal || at23) begin
        tens_d = 4'd0;
        ones_d = 4'd0;
      end else if (ones_q == 4'd9) begin
        tens_d = tens_q + 4'd1;
        ones_d = 4'd0;
      end else begin
        ones_d = ones_q + 4'd1;
      end
    end
  end

  assign pm = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tens_q <= RST_TENS;
      ones_q <= RST_ONES;
    end else begin
      tens_q <= tens_d;
      ones_q <= ones_d;
    end
  end

endmodule
